// File: rtl/digit_bcd_conv_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package digit_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    function automatic longint unsigned bcd_max(input int digits);
        longint unsigned m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        return m - 1;
    endfunction

    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

    localparam int DEF_BIN_WIDTH = 20;
    localparam int CNT_W         = cnt_width(DEF_BIN_WIDTH);

endpackage

// File: rtl/digit_bcd_conv_dabble_step.sv
// One double-dabble iteration: per-nibble +3 correction, then shift in one bit.
module bcd_dabble_step #(
    parameter int DIGITS = 6
) (
    input  logic [DIGITS*4-1:0] bcd_in,
    input  logic                bit_in,
    output logic [DIGITS*4-1:0] bcd_out
);
    logic [DIGITS*4-1:0] corr;
    logic                unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign corr[g*4 +: 4] = (bcd_in[g*4 +: 4] >= 4'd5) ? bcd_in[g*4 +: 4] + 4'd3
                                                            : bcd_in[g*4 +: 4];
    end

    // Saturated input keeps the top digit <= 9, so the bit shifted out is always 0.
    assign {unused_msb, bcd_out} = {corr, bit_in};

endmodule

// File: rtl/digit_bcd_conv.sv
// Sequential binary-to-packed-BCD converter for the LCD digit overlay, with optional frame-locked output.
module digit_bcd_conv
    import digit_bcd_pkg::*;
#(
    parameter int BIN_WIDTH     = 20,
    parameter int DIGITS        = 6,
    parameter int SYNC_TO_FRAME = 1
) (
    input  logic                 lcd_pclk,
    input  logic                 sys_rst,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    input  logic                 frame_start,
    output logic [DIGITS*4-1:0]  data,
    output logic                 data_upd,
    output logic                 overflow,
    output logic                 busy
);
    localparam int                   BCD_W = DIGITS * 4;
    localparam int                   CW    = cnt_width(BIN_WIDTH);
    localparam logic [BIN_WIDTH-1:0] MAX   = BIN_WIDTH'(bcd_max(DIGITS));
    localparam logic [CW-1:0]        LAST  = CW'(BIN_WIDTH - 1);

    state_e               state_q, state_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]     data_q, data_d;
    logic                 ovf_q, ovf_d;
    logic                 upd_q, upd_d;
    logic [BCD_W-1:0]     step_bcd;
    logic                 over;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in  (bcd_q),
        .bit_in  (bin_q[BIN_WIDTH-1]),
        .bcd_out (step_bcd)
    );

    assign over = (bin_in > MAX);

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        upd_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    bin_d      = over ? MAX : bin_in;
                    ovf_pend_d = over;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = step_bcd;
                bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                // Frame-locked mode waits for vsync so the overlay never tears.
                if (SYNC_TO_FRAME == 0 || frame_start) begin
                    data_d  = bcd_q;
                    ovf_d   = ovf_pend_q;
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge lcd_pclk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            upd_q      <= upd_d;
        end
    end

    assign bin_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign data      = data_q;
    assign overflow  = ovf_q;
    assign data_upd  = upd_q;

endmodule

// File: tb/tb_digit_bcd_conv.sv
// Scoreboard bench: dut0 runs free (SYNC_TO_FRAME=0), dut1 is frame-locked (SYNC_TO_FRAME=1).
module tb_digit_bcd_conv;
    localparam int BW = 20;
    localparam int DG = 6;

    typedef struct {
        logic [DG*4-1:0] d;
        logic            o;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst         [2];
    logic [BW-1:0]   bin_in      [2];
    logic            bin_valid   [2];
    logic            frame_start [2];
    logic            bin_ready   [2];
    logic [DG*4-1:0] data        [2];
    logic            data_upd    [2];
    logic            overflow    [2];
    logic            busy        [2];

    exp_t            q0[$];
    exp_t            q1[$];
    logic [DG*4-1:0] disp_d [2];
    logic            disp_o [2];
    bit              in_rst [2];
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    digit_bcd_conv #(.BIN_WIDTH(BW), .DIGITS(DG), .SYNC_TO_FRAME(0)) dut0 (
        .lcd_pclk(clk), .sys_rst(rst[0]), .bin_in(bin_in[0]), .bin_valid(bin_valid[0]),
        .bin_ready(bin_ready[0]), .frame_start(frame_start[0]), .data(data[0]),
        .data_upd(data_upd[0]), .overflow(overflow[0]), .busy(busy[0]));

    digit_bcd_conv #(.BIN_WIDTH(BW), .DIGITS(DG), .SYNC_TO_FRAME(1)) dut1 (
        .lcd_pclk(clk), .sys_rst(rst[1]), .bin_in(bin_in[1]), .bin_valid(bin_valid[1]),
        .bin_ready(bin_ready[1]), .frame_start(frame_start[1]), .data(data[1]),
        .data_upd(data_upd[1]), .overflow(overflow[1]), .busy(busy[1]));

    // Reference: saturate, then peel decimal digits with / and %.
    function automatic exp_t model(input longint unsigned v);
        exp_t r;
        longint unsigned s;
        s   = (v > 999999) ? 999999 : v;
        r.o = (v > 999999);
        r.d = '0;
        for (int k = 0; k < DG; k++) begin
            r.d[k*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (in_rst[i]) return;
        if (data_upd[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                n_cmp++;
                n_err++;
                $display("FAIL upd%0d: unexpected data_upd, data=%h, want no update", i, data[i]);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                disp_d[i] = e.d;
                disp_o[i] = e.o;
            end
        end
        chk($sformatf("data%0d", i), 64'(data[i]), 64'(disp_d[i]));
        chk($sformatf("ovf%0d", i), 64'(overflow[i]), 64'(disp_o[i]));
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    // Drive one request cycle from a negedge; expectation is queued only if it will be accepted.
    task automatic req(input int i, input logic [BW-1:0] v);
        bin_in[i]    = v;
        bin_valid[i] = 1'b1;
        if (bin_ready[i]) begin
            if (i == 0) q0.push_back(model(64'(v)));
            else        q1.push_back(model(64'(v)));
        end
        @(negedge clk);
        bin_valid[i] = 1'b0;
    endtask

    task automatic wait_upd(input int i, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (data_upd[i]) return;
            @(negedge clk);
        end
        n_cmp++;
        n_err++;
        $display("FAIL timeout%0d: no data_upd within %0d cycles, want one", i, budget);
    endtask

    task automatic pulse_frame(input int i);
        frame_start[i] = 1'b1;
        @(negedge clk);
        frame_start[i] = 1'b0;
    endtask

    task automatic chk_idle(input int i);
        chk($sformatf("rst_data%0d", i), 64'(data[i]), 64'h0);
        chk($sformatf("rst_ovf%0d", i), 64'(overflow[i]), 64'h0);
        chk($sformatf("rst_upd%0d", i), 64'(data_upd[i]), 64'h0);
        chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'h0);
        chk($sformatf("rst_ready%0d", i), 64'(bin_ready[i]), 64'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] dir [5];
        logic [BW-1:0] v;
        dir = '{20'd0, 20'd999999, 20'd1000000, 20'hFFFFF, 20'd42};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; bin_in[i] = '0; bin_valid[i] = 1'b0; frame_start[i] = 1'b0;
            in_rst[i] = 1'b1; disp_d[i] = '0; disp_o[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk_idle(0);
        chk_idle(1);
        @(negedge clk);
        in_rst[0] = 1'b0; in_rst[1] = 1'b0;

        // Exact latency on the free-running instance.
        req(0, 20'd123456);
        for (int c = 0; c <= 20; c++) begin
            chk($sformatf("lat_ready_E%0d", c), 64'(bin_ready[0]), 64'h0);
            chk($sformatf("lat_upd_E%0d", c), 64'(data_upd[0]), 64'h0);
            @(negedge clk);
        end
        chk("lat_upd_E21", 64'(data_upd[0]), 64'h1);
        chk("lat_data_E21", 64'(data[0]), 64'h123456);
        chk("lat_ready_E21", 64'(bin_ready[0]), 64'h1);
        @(negedge clk);
        chk("lat_upd_pulse", 64'(data_upd[0]), 64'h0);

        foreach (dir[k]) begin
            req(0, dir[k]);
            wait_upd(0, 40);
            @(negedge clk);
        end

        for (int n = 0; n < 25; n++) begin
            v = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(999990, 20'hFFFFF))
                                            : BW'($urandom_range(0, 999999));
            req(0, v);
            wait_upd(0, 40);
            @(negedge clk);
        end

        // Request while busy is dropped; only the first value appears.
        req(0, 20'd555);
        repeat (5) @(negedge clk);
        req(0, 20'd777);
        wait_upd(0, 40);
        repeat (30) @(negedge clk);
        chk("drop_data", 64'(data[0]), 64'h000555);

        // Reset at E10 discards the in-flight conversion.
        req(0, 20'd314159);
        repeat (9) @(negedge clk);
        in_rst[0] = 1'b1;
        rst[0]    = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk_idle(0);
        q0.delete();
        disp_d[0] = '0;
        disp_o[0] = 1'b0;
        @(negedge clk);
        chk("rst_upd_after", 64'(data_upd[0]), 64'h0);
        in_rst[0] = 1'b0;
        repeat (25) @(negedge clk);
        req(0, 20'd271828);
        wait_upd(0, 40);
        chk("post_rst_data", 64'(data[0]), 64'h271828);
        @(negedge clk);

        // Frame-locked instance: establish a non-zero old value first.
        req(1, 20'd31);
        repeat (25) @(negedge clk);
        pulse_frame(1);
        chk("fr_first", 64'(data[1]), 64'h000031);
        req(1, 20'd2024);
        for (int c = 0; c < 120; c++) begin
            chk("fr_wait_upd", 64'(data_upd[1]), 64'h0);
            @(negedge clk);
        end
        pulse_frame(1);
        chk("fr_upd", 64'(data_upd[1]), 64'h1);
        chk("fr_data", 64'(data[1]), 64'h002024);
        for (int p = 0; p < 3; p++) begin
            repeat (7) @(negedge clk);
            pulse_frame(1);
            chk("fr_hold_upd", 64'(data_upd[1]), 64'h0);
            chk("fr_hold_data", 64'(data[1]), 64'h002024);
        end

        // frame_start during SHIFT and on the DONE-entry edge must not load.
        req(1, 20'd654321);
        repeat (4) @(negedge clk);
        pulse_frame(1);
        chk("fr_shift_upd", 64'(data_upd[1]), 64'h0);
        repeat (14) @(negedge clk);
        pulse_frame(1);
        chk("fr_entry_upd", 64'(data_upd[1]), 64'h0);
        repeat (3) @(negedge clk);
        chk("fr_done_upd", 64'(data_upd[1]), 64'h0);
        chk("fr_done_busy", 64'(busy[1]), 64'h1);
        pulse_frame(1);
        chk("fr_late_upd", 64'(data_upd[1]), 64'h1);
        chk("fr_late_data", 64'(data[1]), 64'h654321);

        req(1, 20'd1000001);
        repeat (25) @(negedge clk);
        pulse_frame(1);
        chk("fr_ovf", 64'(overflow[1]), 64'h1);

        for (int n = 0; n < 6; n++) begin
            req(1, BW'($urandom_range(0, 20'hFFFFF)));
            repeat (21 + $urandom_range(0, 10)) @(negedge clk);
            pulse_frame(1);
            wait_upd(1, 3);
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("drain0", 64'(q0.size()), 64'h0);
        chk("drain1", 64'(q1.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
